// File: rtl/sram_like_slave_if.sv
// Like-SRAM data bus between the CPU memory pipeline (master) and the
// data-memory responder (slave).
//   req/wr/size/wstrb/addr/wdata : request channel, master -> slave
//   addr_ok                      : request accepted when req && addr_ok
//   data_ok/rdata                : one-cycle response strobe and read data
//   resp_stall                   : verification hook, suppresses the next data_ok
interface sram_like_slave_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic [31:0] rdata;
  logic        data_ok;
  logic        resp_stall;

  modport slave (
    input  req, wr, size, wstrb, addr, wdata, resp_stall,
    output addr_ok, rdata, data_ok
  );

  modport master (
    output req, wr, size, wstrb, addr, wdata, resp_stall,
    input  addr_ok, rdata, data_ok
  );
endinterface

// File: rtl/sram_like_slave.sv
// Data-memory responder for the like-SRAM bus.
// Word-addressed array (2^ADDR_W x 32, upper address bits alias), fixed
// minimum latency, at most MAX_OUTS outstanding requests, responses in
// acceptance order.
// Ports:
//   clk    : clock, all state on the rising edge
//   resetn : asynchronous active-low reset (array contents are kept)
//   bus    : slave side of sram_like_slave_if
module sram_like_slave #(
  parameter int ADDR_W   = 12,
  parameter int LATENCY  = 2,   // 1..15
  parameter int MAX_OUTS = 2    // 1..8, also queue depth
) (
  input  logic               clk,
  input  logic               resetn,
  sram_like_slave_if.slave   bus
);

  localparam int PW    = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(MAX_OUTS - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] mem_q [DEPTH];

  // response queue: data plus a saturating age counter per slot
  logic [31:0] qdata_q [MAX_OUTS];
  logic [3:0]  qcnt_q  [MAX_OUTS];
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  logic [3:0]  count_q,  count_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] rdata_q,  rdata_d;

  logic              addr_ok;
  logic              acc;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       push_data;
  logic [3:0]        pend;
  ptr_t              head;
  logic              cand_vld;
  logic [31:0]       cand_data;
  logic              unused_bus;

  // size is informational, upper address bits alias onto the array
  assign unused_bus = ^{bus.size, bus.addr};

  // no look-ahead at the data_ok leaving this cycle
  assign addr_ok   = resetn && (count_q < 4'(MAX_OUTS));
  assign acc       = bus.req && addr_ok;
  assign widx      = bus.addr[ADDR_W+1:2];
  assign push_data = bus.wr ? 32'h0 : mem_q[widx];

  // The entry answered by the current data_ok is still in the queue until
  // the end of this cycle, so the next candidate is the one behind it.
  assign pend = count_q - {3'b000, data_ok_q};
  assign head = data_ok_q ? ptr_inc(rd_ptr_q) : rd_ptr_q;

  always_comb begin
    cand_vld  = 1'b0;
    cand_data = 32'h0;
    if (pend != 4'd0) begin
      // counter starts at LATENCY-1 in cycle C+1; <=1 means C+LATENCY <= X+1
      cand_vld  = (qcnt_q[head] <= 4'd1);
      cand_data = qdata_q[head];
    end else if (LATENCY == 1 && acc) begin
      // empty queue bypass: respond the cycle after acceptance
      cand_vld  = 1'b1;
      cand_data = push_data;
    end
  end

  always_comb begin
    data_ok_d = cand_vld && !bus.resp_stall;
    rdata_d   = data_ok_d ? cand_data : rdata_q;
    count_d   = count_q + {3'b000, acc} - {3'b000, data_ok_q};
    rd_ptr_d  = data_ok_q ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d  = acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= 4'd0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_OUTS; i++) begin
        qdata_q[i] <= 32'h0;
        qcnt_q[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTS; i++) begin
        if (acc && wr_ptr_q == ptr_t'(i)) begin
          qdata_q[i] <= push_data;
          qcnt_q[i]  <= 4'(LATENCY - 1);
        end else if (qcnt_q[i] != 4'd0) begin
          qcnt_q[i] <= qcnt_q[i] - 4'd1;
        end
      end
    end
  end

  // array is not reset; writes land at the accept edge, byte-masked
  always_ff @(posedge clk) begin
    if (acc && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem_q[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  assign bus.addr_ok = addr_ok;
  assign bus.data_ok = data_ok_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three configurations driven by the same
// request stream and compared every cycle against a cycle-number model.
module tb_sram_like_slave;
  localparam int L0 = 2, M0 = 2;
  localparam int L1 = 3, M1 = 2;
  localparam int L2 = 1, M2 = 4;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        req = 1'b0, wr = 1'b0, stall = 1'b0;
  logic [1:0]  size = 2'd2;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;

  sram_like_slave_if ba ();
  sram_like_slave_if bb ();
  sram_like_slave_if bc ();

  assign ba.req = req; assign ba.wr = wr; assign ba.size = size; assign ba.wstrb = wstrb;
  assign ba.addr = addr; assign ba.wdata = wdata; assign ba.resp_stall = stall;
  assign bb.req = req; assign bb.wr = wr; assign bb.size = size; assign bb.wstrb = wstrb;
  assign bb.addr = addr; assign bb.wdata = wdata; assign bb.resp_stall = stall;
  assign bc.req = req; assign bc.wr = wr; assign bc.size = size; assign bc.wstrb = wstrb;
  assign bc.addr = addr; assign bc.wdata = wdata; assign bc.resp_stall = stall;

  sram_like_slave #(.ADDR_W(12), .LATENCY(L0), .MAX_OUTS(M0)) dut_a (.clk(clk), .resetn(resetn), .bus(ba));
  sram_like_slave #(.ADDR_W(12), .LATENCY(L1), .MAX_OUTS(M1)) dut_b (.clk(clk), .resetn(resetn), .bus(bb));
  sram_like_slave #(.ADDR_W(12), .LATENCY(L2), .MAX_OUTS(M2)) dut_c (.clk(clk), .resetn(resetn), .bus(bc));

  logic        aok_o [3];
  logic        dok_o [3];
  logic [31:0] rd_o  [3];
  assign aok_o[0] = ba.addr_ok; assign dok_o[0] = ba.data_ok; assign rd_o[0] = ba.rdata;
  assign aok_o[1] = bb.addr_ok; assign dok_o[1] = bb.data_ok; assign rd_o[1] = bb.rdata;
  assign aok_o[2] = bc.addr_ok; assign dok_o[2] = bc.data_ok; assign rd_o[2] = bc.rdata;

  always #5 clk = ~clk;

  // model: each accepted request becomes {data, cycle at which it may answer}
  typedef struct {
    logic [31:0] d;
    int          rdy;
  } ent_t;

  ent_t        mq   [3][$];
  logic [31:0] mm   [3][4096];
  int          mcnt [3];
  logic        mdok [3];
  logic [31:0] mrd  [3];
  int          lat  [3] = '{L0, L1, L2};
  int          mx   [3] = '{M0, M1, M2};

  int          n_chk = 0, n_err = 0, cyc = 0, mark = 0;
  logic [31:0] dok_h [3];
  logic [31:0] aok_h [3];
  logic        last_aok [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic mclear();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mcnt[i] = 0;
      mdok[i] = 1'b0;
      mrd[i]  = 32'h0;
    end
  endtask

  task automatic set_mark();
    mark = cyc;
    for (int i = 0; i < 3; i++) begin
      dok_h[i] = 32'h0;
      aok_h[i] = 32'h0;
    end
  endtask

  // one bus cycle: drive, check at negedge, advance model, move past posedge
  task automatic step(input logic r, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d, input logic st);
    logic eaok;
    int   idx;
    ent_t e;
    req = r; wr = w; wstrb = s; addr = a; wdata = d; stall = st;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      eaok = resetn && (mcnt[i] < mx[i]);
      chk($sformatf("addr_ok[%0d] c%0d", i, cyc), {31'b0, aok_o[i]}, {31'b0, eaok});
      chk($sformatf("data_ok[%0d] c%0d", i, cyc), {31'b0, dok_o[i]}, {31'b0, mdok[i]});
      chk($sformatf("rdata[%0d] c%0d", i, cyc), rd_o[i], mrd[i]);
      last_aok[i] = aok_o[i];
      if (cyc - mark >= 0 && cyc - mark < 32) begin
        dok_h[i][cyc-mark] = dok_o[i];
        aok_h[i][cyc-mark] = aok_o[i];
      end
      if (!resetn) begin
        mq[i].delete();
        mcnt[i] = 0;
        mdok[i] = 1'b0;
        mrd[i]  = 32'h0;
      end else begin
        if (mdok[i]) begin
          void'(mq[i].pop_front());
          mcnt[i]--;
        end
        if (r && eaok) begin
          idx   = int'((a >> 2) & 32'hFFF);
          e.d   = w ? 32'h0 : mm[i][idx];
          e.rdy = cyc + lat[i];
          mq[i].push_back(e);
          if (w) for (int b = 0; b < 4; b++) if (s[b]) mm[i][idx][8*b +: 8] = d[8*b +: 8];
          mcnt[i]++;
        end
        mdok[i] = (mq[i].size() > 0) && (mq[i][0].rdy <= cyc + 1) && !st;
        if (mdok[i]) mrd[i] = mq[i][0].d;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // asynchronous reset in the middle of the current cycle
  task automatic reset_mid();
    #2 resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst addr_ok[%0d]", i), {31'b0, aok_o[i]}, 32'h0);
      chk($sformatf("rst data_ok[%0d]", i), {31'b0, dok_o[i]}, 32'h0);
      chk($sformatf("rst rdata[%0d]", i), rd_o[i], 32'h0);
    end
    mclear();
  endtask

  initial begin
    logic [31:0] ra;
    int k, t;
    mclear();
    @(posedge clk);
    #1;
    idle(3);
    resetn = 1'b1;
    idle(2);

    // give every word used below a known value
    for (int j = 0; j < 16; j++) begin
      step(1'b1, 1'b1, 4'hF, 32'(j * 4), $urandom, 1'b0);
      idle(4);
    end

    // write then read back-to-back
    set_mark();
    step(1'b1, 1'b1, 4'hF, 32'h10, 32'h12345678, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    idle(5);
    chk("b2b dok a", {26'b0, dok_h[0][5:0]}, 32'b001100);
    chk("b2b dok b", {26'b0, dok_h[1][5:0]}, 32'b011000);
    chk("b2b dok c", {26'b0, dok_h[2][5:0]}, 32'b000110);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b rdata[%0d]", i), rd_o[i], 32'h12345678);

    // partial write of byte 2
    step(1'b1, 1'b1, 4'b0100, 32'h10, 32'hAABBCCDD, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) chk($sformatf("partial[%0d]", i), rd_o[i], 32'h12BB5678);

    // address aliasing
    step(1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'hCAFEF00D, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 4'h0, 32'h0000_4004, 32'h0, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) chk($sformatf("alias[%0d]", i), rd_o[i], 32'hCAFEF00D);

    // outstanding limit on dut_b: req held until it accepts each read
    set_mark();
    k = 0; t = 0;
    while (k < 4 && t < 40) begin
      step(1'b1, 1'b0, 4'h0, 32'(k * 4), 32'h0, 1'b0);
      if (last_aok[1]) k++;
      t++;
    end
    chk("limit accepts", 32'(k), 32'd4);
    idle(6);
    chk("limit aok b", {26'b0, aok_h[1][5:0]}, 32'b110011);
    chk("limit dok b", {22'b0, dok_h[1][9:0]}, 32'b0110011000);

    // stall: reads in cycles 0-4, resp_stall high cycles 0-5
    set_mark();
    for (int j = 0; j < 6; j++) step(j < 5, 1'b0, 4'h0, 32'(j * 4), 32'h0, 1'b1);
    idle(7);
    chk("stall aok c", {27'b0, aok_h[2][4:0]}, 32'b01111);
    chk("stall dok c", {20'b0, dok_h[2][11:0]}, 32'b011110000000);

    // reset with reads in flight
    step(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
    reset_mid();
    idle(2);
    resetn = 1'b1;
    idle(3);
    step(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0);
    idle(4);
    for (int i = 0; i < 3; i++) chk($sformatf("post-rst[%0d]", i), rd_o[i], 32'hCAFEF00D);

    // random traffic over 16 words with random alias bits
    repeat (600) begin
      ra       = $urandom;
      ra[13:6] = 8'h0;
      ra[5:2]  = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           ra, $urandom, $urandom_range(0, 3) == 0);
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish, expected finish before 300000");
    $fatal(1, "timeout");
  end

endmodule
